// File: rtl/gb_cpu_interrupt_ctrl_if.sv
// CPU bus view of the interrupt controller: IF (0xFF0F) and IE (0xFFFF) accesses.
interface gb_cpu_interrupt_ctrl_if;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_wr;
   logic [7:0]  bus_rdata;
   logic        bus_hit;

   modport master (output bus_addr, bus_wdata, bus_wr, input bus_rdata, bus_hit);
   modport slave  (input bus_addr, bus_wdata, bus_wr, output bus_rdata, bus_hit);
endinterface

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy interrupt controller: IF/IE/IME, EI delay, HALT wake-up and the
// 5 M-cycle dispatch sequence ending in a vector load.
module gb_cpu_interrupt_ctrl (
   input  logic                          clk,
   input  logic                          reset,
   gb_cpu_interrupt_ctrl_if.slave        bus,
   input  logic [4:0]                    irq_req,
   input  logic                          instr_boundary,
   input  logic                          ei_req,
   input  logic                          di_req,
   input  logic                          reti_req,
   input  logic                          halt_req,
   output logic                          int_pending,
   input  logic                          int_ack,
   output logic [2:0]                    dispatch_phase,
   output logic                          halted,
   output logic                          write_interrupt_vector,
   output logic [7:0]                    interrupt_vector
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT0   = 3'd1,
      ST_WAIT1   = 3'd2,
      ST_PUSH_HI = 3'd3,
      ST_PUSH_LO = 3'd4,
      ST_JUMP    = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  if_q, if_d;
   logic [7:0]  ie_q, ie_d;
   logic        ime_q, ime_d;
   logic        ei_pend_q, ei_pend_d;
   logic        halted_q, halted_d;
   logic [7:0]  vec_q, vec_d;
   logic [4:0]  vec_bit_q, vec_bit_d;

   logic [4:0]  dispatch_clear;
   logic [4:0]  latch_src;
   logic        wr_if, wr_ie, ack, promote, any_req;

   // ---------------- register / IME / HALT next-state ----------------
   always_comb begin
      wr_if   = bus.bus_wr && (bus.bus_addr == 16'hFF0F);
      wr_ie   = bus.bus_wr && (bus.bus_addr == 16'hFFFF);
      ack     = int_ack && (state_q == ST_IDLE);
      promote = ei_pend_q && instr_boundary;
      any_req = |(if_q & ie_q[4:0]);

      if_d = ((wr_if ? bus.bus_wdata[4:0] : if_q) & ~dispatch_clear) | irq_req;
      ie_d = wr_ie ? bus.bus_wdata : ie_q;

      ime_d = ime_q;
      if (reti_req || promote) ime_d = 1'b1;
      if (di_req || ack)       ime_d = 1'b0;

      ei_pend_d = ei_pend_q;
      if (di_req)       ei_pend_d = 1'b0;
      else if (ei_req)  ei_pend_d = 1'b1;
      else if (promote) ei_pend_d = 1'b0;

      halted_d = halted_q;
      if (any_req)       halted_d = 1'b0;
      else if (halt_req) halted_d = 1'b1;

      // Arbitrate on next-state IF/IE so a PUSH_HI write to 0xFFFF can cancel.
      latch_src = if_d & ie_d[4:0];
      vec_d     = vec_q;
      vec_bit_d = vec_bit_q;
      if (state_q == ST_PUSH_HI) begin
         vec_d     = '0;
         vec_bit_d = '0;
         for (int unsigned i = 0; i < 5; i++) begin
            if (latch_src[i] && (vec_bit_d == '0)) begin
               vec_bit_d = 5'b1 << i;
               vec_d     = 8'h40 | 8'(i << 3);
            end
         end
      end
   end

   // ---------------- dispatch FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         if_q      <= '0;
         ie_q      <= '0;
         ime_q     <= 1'b0;
         ei_pend_q <= 1'b0;
         halted_q  <= 1'b0;
         vec_q     <= '0;
         vec_bit_q <= '0;
      end else begin
         state_q   <= state_d;
         if_q      <= if_d;
         ie_q      <= ie_d;
         ime_q     <= ime_d;
         ei_pend_q <= ei_pend_d;
         halted_q  <= halted_d;
         vec_q     <= vec_d;
         vec_bit_q <= vec_bit_d;
      end
   end

   // ---------------- dispatch FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (ack) state_d = ST_WAIT0;
         ST_WAIT0:   state_d = ST_WAIT1;
         ST_WAIT1:   state_d = ST_PUSH_HI;
         ST_PUSH_HI: state_d = ST_PUSH_LO;
         ST_PUSH_LO: state_d = ST_JUMP;
         ST_JUMP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // ---------------- dispatch FSM: outputs ----------------
   always_comb begin
      dispatch_phase         = state_q;
      write_interrupt_vector = (state_q == ST_JUMP);
      interrupt_vector       = (state_q == ST_JUMP) ? vec_q : '0;
      dispatch_clear         = (state_q == ST_JUMP) ? vec_bit_q : '0;
   end

   always_comb begin
      int_pending = ime_q && any_req;
      halted      = halted_q;
      bus.bus_hit = (bus.bus_addr == 16'hFF0F) || (bus.bus_addr == 16'hFFFF);
      if (bus.bus_addr == 16'hFF0F)      bus.bus_rdata = {3'b111, if_q};
      else if (bus.bus_addr == 16'hFFFF) bus.bus_rdata = ie_q;
      else                               bus.bus_rdata = '0;
   end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
# gb_cpu_interrupt_ctrl

Interrupt controller for the Game Boy CPU. It holds IF (0xFF0F), IE (0xFFFF) and IME, and decides when an interrupt is taken. It runs the 5 M-cycle interrupt dispatch sequence and, at the end, drives `write_interrupt_vector` / `interrupt_vector` into the register file, which loads PC with {0x00, vector}. It also owns HALT wake-up.

## Interface
- No parameters; five interrupt sources, fixed.
- `clk`  in  1  machine clock (one edge per M-cycle); reset reset, synchronous, active-high; clock clk.
- `reset`  in  1  synchronous, active-high.
- `irq_req`  in  5  one-cycle request pulses; bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad.
- `bus_addr`  in  16  CPU bus address.
- `bus_wdata`  in  8  CPU write data.
- `bus_wr`  in  1  write strobe.
- `bus_rdata`  out  8  combinational read data for IF/IE.
- `bus_hit`  out  1  `bus_addr` is 0xFF0F or 0xFFFF.
- `instr_boundary`  in  1  pulse in the final M-cycle of each instruction.
- `ei_req`  in  1  EI executing (asserted with its `instr_boundary`).
- `di_req`  in  1  DI executing.
- `reti_req`  in  1  RETI executing; sets IME immediately.
- `halt_req`  in  1  HALT executing.
- `int_pending`  out  1  IME & |(IF & IE & 5'h1F); the control unit samples it at `instr_boundary`.
- `int_ack`  in  1  control unit commits to dispatch (only legal when `int_pending` is 1 during `instr_boundary`).
- `dispatch_phase`  out  3  0 idle, 1 WAIT0, 2 WAIT1, 3 PUSH_HI, 4 PUSH_LO, 5 JUMP.
- `halted`  out  1  CPU is halted.
- `write_interrupt_vector`  out  1  one-cycle pulse in JUMP.
- `interrupt_vector`  out  8  vector low byte: 0x40/48/50/58/60, or 0x00 if cancelled.

## Operation
- IF[4:0] update each edge, in this order: IF_next = (bus write to 0xFF0F ? wdata[4:0] : IF) & ~dispatch_clear | irq_req. A request always wins over a same-cycle write or clear.
- IF reads return {3'b111, IF}. IE stores and reads back all 8 bits; only IE[4:0] participate in arbitration.
- IME is cleared by DI and by `int_ack`, both at the next edge.
- `ei_req` sets `ei_pending`. IME becomes 1 at the edge ending the next `instr_boundary` cycle after the EI cycle, so the instruction following EI executes before any interrupt can be taken.
- DI in the cycle after EI cancels `ei_pending`. `reti_req` sets IME at the next edge.
- `int_ack` has priority over a same-cycle `ei_pending` promotion.
- The dispatch FSM runs IDLE→WAIT0→WAIT1→PUSH_HI→PUSH_LO→JUMP→IDLE, one state per cycle, entered on `int_ack`.
  - The control unit drives the SP decrements and pushes from `dispatch_phase`.
  - At the end of PUSH_HI, the vector is latched from the lowest set bit of IF & IE[4:0], computed at that time, not at ack.
  - If IF & IE is zero at that point (for example, cleared by the PUSH_HI write landing on 0xFFFF), the vector is 0x00 and no IF bit is cleared.
  - In JUMP: `write_interrupt_vector` = 1, `interrupt_vector` = latched value, and `dispatch_clear` = the one-hot bit that was latched, applied at the edge ending JUMP.
- HALT: `halt_req` sets `halted` at the next edge.
  - `halted` clears at the edge after any cycle where |(IF & IE[4:0]) = 1, regardless of IME.
  - If IF & IE is already nonzero during `halt_req`, `halted` never asserts.
  - The HALT bug is out of scope.
- A bus write while dispatch is in progress updates IF/IE normally.

## Timing
- Reset values: IF 0, IE 0, IME 0, `ei_pending` 0, FSM IDLE, `halted` 0, `int_pending` 0, `write_interrupt_vector` 0, `interrupt_vector` 0x00, `dispatch_phase` 0.
- Reset mid-dispatch returns to IDLE at once with no JUMP pulse.
- `int_pending`, `bus_rdata` and `bus_hit` are combinational from registered state and bus inputs.
- `irq_req` shows in IF, and in `int_pending` if IME=IE=1, one cycle after the pulse.
- `int_ack` at cycle N: `dispatch_phase` = 1 at N+1 and JUMP at N+5. The vector is latched from state at N+3.
- `int_ack` while not IDLE is ignored.

## Test plan
- IE=0x05, IME=1, `irq_req`=0x05 → `int_pending` next cycle; after ack the JUMP pulse carries vector 0x40; IF becomes 0x04; IME=0.
- EI then NOP with IF&IE≠0 → `int_pending` stays 0 through the NOP's `instr_boundary` and rises in the next cycle; EI immediately followed by DI → IME stays 0.
- Dispatch of Timer (IF=IE=0x04), write IE=0x00 during PUSH_HI → `interrupt_vector`=0x00, IF stays 0x04.
- IME=0, IE=0x10, HALT, then `irq_req`=0x10 → `halted` is 1 until 2 cycles after the pulse, then 0; no dispatch.
- Write IF=0x00 in the same cycle as `irq_req`=0x02 → IF reads 0xE2; IE write 0xFF → reads 0xFF.
- Assert reset during WAIT1 → `dispatch_phase`=0, no JUMP pulse, IF=IE=0.
